// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the FSM state encoding, the stream framing constants and a small
// helper that decides which states accept stream bytes.
package boot_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_LO = 3'd1;
  localparam logic [2:0] LEN_HI = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] CSUM   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERROR  = 3'd6;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

  // States in which the loader consumes bytes from the stream.
  function automatic logic takes_bytes(input logic [2:0] st);
    return (st == LEN_LO) || (st == LEN_HI) || (st == DATA) || (st == CSUM);
  endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Packs accepted stream bytes into little-endian words.
// The first byte of a word lands in bits [7:0]. After the fourth byte is
// accepted, the assembled word and a one-cycle word_vld pulse appear on the
// next cycle.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clear         restart packing at byte 0 (new load)
//   accept        byte_in is consumed this cycle
//   byte_in       stream byte
//   idx           index of the next byte within the word (0..3)
//   word_vld      one-cycle pulse, word holds a freshly completed word
//   word          last completed word
module boot_word_packer import boot_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  output logic [1:0]        idx,
  output logic              word_vld,
  output logic [DATA_W-1:0] word
);

  // Bytes 0..2 of the current word; newest byte enters at the top so that
  // after three bytes the register reads {b2, b1, b0}.
  logic [DATA_W-9:0] shreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= 2'd0;
      shreg    <= '0;
      word_vld <= 1'b0;
      word     <= '0;
    end else begin
      word_vld <= 1'b0;
      if (clear) begin
        idx <= 2'd0;
      end else if (accept) begin
        idx <= idx + 2'd1;
        if (idx == 2'(BYTES_PER_WORD - 1)) begin
          word     <= {byte_in, shreg};
          word_vld <= 1'b1;
        end else begin
          shreg <= {byte_in, shreg[DATA_W-9:8]};
        end
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader.
// Receives a framed byte stream (16-bit little-endian word count, the data
// words as little-endian bytes, one XOR checksum byte), writes each word to
// instruction memory and keeps the CPU in reset until a complete image with
// a matching checksum has been loaded.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   start          load request, honoured in IDLE, DONE and ERROR
//   byte_in        stream byte, accepted when byte_valid && byte_ready
//   byte_valid     byte_in is valid
//   byte_ready     loader accepts a byte this cycle
//   imem_we        one-cycle write strobe per completed word
//   imem_addr      word address of the current write
//   imem_wdata     word being written
//   cpu_rst_n      CPU reset (active-low), released only when done
//   done           image loaded and checksum matched
//   error          length overflow or checksum mismatch (sticky)
//   words_loaded   words written during this load
module imem_boot_loader import boot_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

  logic [2:0]       state;
  logic [LEN_W-1:0] len;
  logic [7:0]       csum;
  logic [1:0]       idx;
  logic             word_vld;
  logic             accept;
  logic             accept_data;
  logic             load_req;
  logic             last_byte;
  logic [LEN_W-1:0] len_full;

  assign byte_ready  = takes_bytes(state);
  assign accept      = byte_valid && byte_ready;
  assign accept_data = accept && (state == DATA);
  assign load_req    = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign len_full    = {byte_in, len[7:0]};
  assign imem_we     = word_vld;

  // The previous word's write has always retired before the fourth byte of
  // the next word arrives, so words_loaded is the index of the word in flight.
  assign last_byte = accept_data && (idx == 2'(BYTES_PER_WORD - 1)) &&
                     ((32'(words_loaded) + 32'd1) == 32'(len));

  boot_word_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (load_req),
    .accept   (accept_data),
    .byte_in  (byte_in),
    .idx      (idx),
    .word_vld (word_vld),
    .word     (imem_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      len          <= '0;
      csum         <= 8'd0;
      imem_addr    <= '0;
      words_loaded <= '0;
      cpu_rst_n    <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      // The address seen by the write is the pre-increment value.
      if (word_vld) begin
        imem_addr    <= imem_addr + ADDR_W'(1);
        words_loaded <= words_loaded + (ADDR_W + 1)'(1);
      end
      if (accept_data) begin
        csum <= csum ^ byte_in;
      end

      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state        <= LEN_LO;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            csum         <= 8'd0;
            imem_addr    <= '0;
            cpu_rst_n    <= 1'b0;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= byte_in;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len <= len_full;
            if (len_full == '0) begin
              state <= CSUM;
            end else if (32'(len_full) > MAX_WORDS) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (last_byte) begin
            state <= CSUM;
          end
        end
        CSUM: begin
          if (accept) begin
            if (byte_in == csum) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: frame loads, checksum mismatch,
// empty image, length overflow, gapped stream with stray start pulses and
// reset in the middle of a load.
module tb_imem_boot_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_rst_n;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int errors = 0;

  // Write log filled from the memory port.
  logic [ADDR_W-1:0] wr_addr [0:31];
  logic [DATA_W-1:0] wr_data [0:31];
  int                wn = 0;

  imem_boot_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst_n    (cpu_rst_n),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we && wn < 32) begin
      wr_addr[wn] <= imem_addr;
      wr_data[wn] <= imem_wdata;
      wn          <= wn + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte for one cycle; the loader is expected to be ready.
  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " byte_ready"},   32'(byte_ready),   32'd0);
    check({tag, " imem_we"},      32'(imem_we),      32'd0);
    check({tag, " imem_addr"},    32'(imem_addr),    32'd0);
    check({tag, " imem_wdata"},   imem_wdata,        32'd0);
    check({tag, " cpu_rst_n"},    32'(cpu_rst_n),    32'd0);
    check({tag, " done"},         32'(done),         32'd0);
    check({tag, " error"},        32'(error),        32'd0);
    check({tag, " words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  // Image of case 1: two words, checksum 0x2A.
  logic [7:0] img [0:7];
  int base;

  initial begin
    img[0] = 8'h78; img[1] = 8'h56; img[2] = 8'h34; img[3] = 8'h12;
    img[4] = 8'hEF; img[5] = 8'hBE; img[6] = 8'hAD; img[7] = 8'hDE;
    rst        = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b1;
    tick();
    // byte_valid while idle is not consumed
    send(8'h55);
    check("idle ready", 32'(byte_ready), 32'd0);

    // Case 1: two-word load, checksum match
    base = wn;
    pulse_start();
    check("c1 ready after start", 32'(byte_ready), 32'd1);
    send(8'h02);
    send(8'h00);
    for (int i = 0; i < 4; i++) send(img[i]);
    check("c1 we word0",    32'(imem_we),   32'd1);
    check("c1 addr word0",  32'(imem_addr), 32'd0);
    check("c1 wdata word0", imem_wdata,     32'h12345678);
    for (int i = 4; i < 8; i++) send(img[i]);
    check("c1 we word1",    32'(imem_we),   32'd1);
    check("c1 addr word1",  32'(imem_addr), 32'd1);
    check("c1 wdata word1", imem_wdata,     32'hDEADBEEF);
    check("c1 done before csum", 32'(done), 32'd0);
    send(8'h2A);
    check("c1 done",         32'(done),         32'd1);
    check("c1 cpu_rst_n",    32'(cpu_rst_n),    32'd1);
    check("c1 error",        32'(error),        32'd0);
    check("c1 words_loaded", 32'(words_loaded), 32'd2);
    check("c1 ready in done", 32'(byte_ready),  32'd0);
    check("c1 write count",  32'(wn - base),    32'd2);
    check("c1 log addr0",    32'(wr_addr[base]),     32'd0);
    check("c1 log data0",    wr_data[base],          32'h12345678);
    check("c1 log addr1",    32'(wr_addr[base + 1]), 32'd1);
    check("c1 log data1",    wr_data[base + 1],      32'hDEADBEEF);
    tick();
    check("c1 done holds",   32'(done),         32'd1);

    // Case 2: same image, bad checksum
    base = wn;
    pulse_start();
    check("c2 done cleared",  32'(done),         32'd0);
    check("c2 cpu reset",     32'(cpu_rst_n),    32'd0);
    check("c2 words cleared", 32'(words_loaded), 32'd0);
    send(8'h02);
    send(8'h00);
    for (int i = 0; i < 8; i++) send(img[i]);
    send(8'hD5);
    check("c2 error",        32'(error),      32'd1);
    check("c2 done",         32'(done),       32'd0);
    check("c2 cpu_rst_n",    32'(cpu_rst_n),  32'd0);
    check("c2 ready",        32'(byte_ready), 32'd0);
    check("c2 write count",  32'(wn - base),  32'd2);
    check("c2 log data1",    wr_data[base + 1], 32'hDEADBEEF);
    tick();
    check("c2 error sticky", 32'(error),      32'd1);

    // Case 3: empty image, good then bad checksum
    base = wn;
    pulse_start();
    check("c3 error cleared", 32'(error), 32'd0);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    check("c3 done",        32'(done),      32'd1);
    check("c3 cpu_rst_n",   32'(cpu_rst_n), 32'd1);
    check("c3 no writes",   32'(wn - base), 32'd0);
    pulse_start();
    send(8'h00);
    send(8'h00);
    send(8'h01);
    check("c3b error",      32'(error),     32'd1);
    check("c3b done",       32'(done),      32'd0);

    // Case 4: word count above memory size
    base = wn;
    pulse_start();
    send(8'h01);
    send(8'h01);
    check("c4 error",     32'(error),      32'd1);
    check("c4 ready",     32'(byte_ready), 32'd0);
    send(8'hAA);
    send(8'hBB);
    tick();
    check("c4 no writes", 32'(wn - base),  32'd0);
    check("c4 cpu_rst_n", 32'(cpu_rst_n),  32'd0);

    // Case 5: gapped stream with start pulses in DATA
    base = wn;
    pulse_start();
    send(8'h02);
    tick();
    send(8'h00);
    tick();
    for (int i = 0; i < 8; i++) begin
      send(img[i]);
      if (i == 2 || i == 5) pulse_start();
      else tick();
    end
    check("c5 ready in csum", 32'(byte_ready), 32'd1);
    send(8'h2A);
    check("c5 done",         32'(done),         32'd1);
    check("c5 words_loaded", 32'(words_loaded), 32'd2);
    check("c5 write count",  32'(wn - base),    32'd2);
    check("c5 log addr0",    32'(wr_addr[base]),     32'd0);
    check("c5 log data0",    wr_data[base],          32'h12345678);
    check("c5 log addr1",    32'(wr_addr[base + 1]), 32'd1);
    check("c5 log data1",    wr_data[base + 1],      32'hDEADBEEF);

    // Case 6: reset after six data bytes, then a full reload
    pulse_start();
    send(8'h02);
    send(8'h00);
    for (int i = 0; i < 6; i++) send(img[i]);
    check("c6 partial words", 32'(words_loaded), 32'd1);
    base = wn;
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("c6 in reset");
    tick();
    tick();
    check("c6 no write in reset", 32'(wn - base), 32'd0);
    rst = 1'b1;
    tick();
    base = wn;
    pulse_start();
    send(8'h02);
    send(8'h00);
    for (int i = 0; i < 8; i++) send(img[i]);
    send(8'h2A);
    check("c6 done",         32'(done),      32'd1);
    check("c6 cpu_rst_n",    32'(cpu_rst_n), 32'd1);
    check("c6 write count",  32'(wn - base), 32'd2);
    check("c6 log addr0",    32'(wr_addr[base]),     32'd0);
    check("c6 log data0",    wr_data[base],          32'h12345678);
    check("c6 log addr1",    32'(wr_addr[base + 1]), 32'd1);
    check("c6 log data1",    wr_data[base + 1],      32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
